// File: rtl/bram32_arbiter.sv
// Two-port valid/ready front end that shares one bram32 with single-cycle response latency.
// Define BRAM32_ARB_RR_EN for round-robin arbitration on contention; the default is fixed priority with port 0 winning.
module bram32_arbiter #(
    parameter  int DEPTH = 512,
    localparam int AW    = $clog2(DEPTH),
    localparam int BA    = AW + 2
) (
    input  logic          i_clk,
    input  logic          i_rst,

    input  logic          i_p0_req_valid,
    output logic          o_p0_req_ready,
    input  logic [BA-1:0] i_p0_req_addr,
    input  logic          i_p0_req_we,
    input  logic [1:0]    i_p0_req_size,
    input  logic [31:0]   i_p0_req_wdata,
    output logic          o_p0_resp_valid,
    output logic [31:0]   o_p0_resp_rdata,
    output logic          o_p0_resp_err,

    input  logic          i_p1_req_valid,
    output logic          o_p1_req_ready,
    input  logic [BA-1:0] i_p1_req_addr,
    input  logic          i_p1_req_we,
    input  logic [1:0]    i_p1_req_size,
    input  logic [31:0]   i_p1_req_wdata,
    output logic          o_p1_resp_valid,
    output logic [31:0]   o_p1_resp_rdata,
    output logic          o_p1_resp_err,

    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_data,
    output logic          o_mem_we,
    output logic [2:0]    o_mem_subaddr,
    input  logic [31:0]   i_mem_data
);

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size_e'(size))
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            SIZE_WORD: bad = (off != 2'd0);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [2:0] subaddrOf(input logic [1:0] size, input logic [1:0] off);
        logic [2:0] code;
        case (size_e'(size))
            SIZE_WORD: code = 3'd1;
            SIZE_HALF: code = {2'b01, off[1]};
            SIZE_BYTE: code = {1'b1, off};
            default:   code = 3'd0;
        endcase
        return code;
    endfunction

    logic gnt0;
    logic gnt1;
    logic anyGnt;

`ifdef BRAM32_ARB_RR_EN
    // lastGnt_q holds the port granted most recently; the other port wins a tie.
    logic lastGnt_q;
    logic lastGnt_d;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!i_rst) begin
            if (i_p0_req_valid && i_p1_req_valid) begin
                gnt0 = lastGnt_q;
                gnt1 = !lastGnt_q;
            end else begin
                gnt0 = i_p0_req_valid;
                gnt1 = i_p1_req_valid;
            end
        end
    end

    always_comb begin
        lastGnt_d = lastGnt_q;
        if (anyGnt) begin
            lastGnt_d = gnt1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lastGnt_q <= 1'b1;
        end else begin
            lastGnt_q <= lastGnt_d;
        end
    end
`else
    always_comb begin
        gnt0 = !i_rst && i_p0_req_valid;
        gnt1 = !i_rst && i_p1_req_valid && !i_p0_req_valid;
    end
`endif

    assign anyGnt         = gnt0 || gnt1;
    assign o_p0_req_ready = gnt0;
    assign o_p1_req_ready = gnt1;

    logic [BA-1:0] selAddr;
    logic          selWe;
    logic [1:0]    selSize;
    logic [31:0]   selWdata;
    logic          selErr;

    always_comb begin
        selAddr  = gnt1 ? i_p1_req_addr  : i_p0_req_addr;
        selWe    = gnt1 ? i_p1_req_we    : i_p0_req_we;
        selSize  = gnt1 ? i_p1_req_size  : i_p0_req_size;
        selWdata = gnt1 ? i_p1_req_wdata : i_p0_req_wdata;
        selErr   = isMisaligned(selSize, selAddr[1:0]);
    end

    // Misaligned or ungranted cycles leave the memory bus fully idle so nothing is written.
    always_comb begin
        o_mem_addr    = '0;
        o_mem_data    = '0;
        o_mem_we      = 1'b0;
        o_mem_subaddr = 3'd0;
        if (anyGnt && !selErr) begin
            o_mem_addr    = selAddr[BA-1:2];
            o_mem_data    = selWdata;
            o_mem_we      = selWe;
            o_mem_subaddr = subaddrOf(selSize, selAddr[1:0]);
        end
    end

    logic       respValid_q, respValid_d;
    logic       respPort_q,  respPort_d;
    logic       respWe_q,    respWe_d;
    logic [1:0] respSize_q,  respSize_d;
    logic [1:0] respOff_q,   respOff_d;
    logic       respErr_q,   respErr_d;

    always_comb begin
        respValid_d = anyGnt;
        respPort_d  = gnt1;
        respWe_d    = selWe;
        respSize_d  = selSize;
        respOff_d   = selAddr[1:0];
        respErr_d   = selErr;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            respValid_q <= 1'b0;
            respPort_q  <= 1'b0;
            respWe_q    <= 1'b0;
            respSize_q  <= 2'd0;
            respOff_q   <= 2'd0;
            respErr_q   <= 1'b0;
        end else begin
            respValid_q <= respValid_d;
            respPort_q  <= respPort_d;
            respWe_q    <= respWe_d;
            respSize_q  <= respSize_d;
            respOff_q   <= respOff_d;
            respErr_q   <= respErr_d;
        end
    end

    logic [31:0] laneData;
    logic [31:0] respData;
    logic        respLive;

    // Gating with i_rst drops a response whose grant happened just before reset rose.
    assign respLive = respValid_q && !i_rst;

    always_comb begin
        laneData = 32'd0;
        case (size_e'(respSize_q))
            SIZE_WORD: laneData = i_mem_data;
            SIZE_HALF: laneData = {16'd0, respOff_q[1] ? i_mem_data[31:16] : i_mem_data[15:0]};
            SIZE_BYTE: begin
                case (respOff_q)
                    2'd0:    laneData = {24'd0, i_mem_data[7:0]};
                    2'd1:    laneData = {24'd0, i_mem_data[15:8]};
                    2'd2:    laneData = {24'd0, i_mem_data[23:16]};
                    default: laneData = {24'd0, i_mem_data[31:24]};
                endcase
            end
            default:   laneData = 32'd0;
        endcase
    end

    assign respData = (respLive && !respWe_q && !respErr_q) ? laneData : 32'd0;

    assign o_p0_resp_valid = respLive && !respPort_q;
    assign o_p1_resp_valid = respLive &&  respPort_q;
    assign o_p0_resp_err   = o_p0_resp_valid && respErr_q;
    assign o_p1_resp_err   = o_p1_resp_valid && respErr_q;
    assign o_p0_resp_rdata = o_p0_resp_valid ? respData : 32'd0;
    assign o_p1_resp_rdata = o_p1_resp_valid ? respData : 32'd0;

endmodule

// File: doc/bram32_arbiter.md
# bram32_arbiter

- Shares one `bram32` instance between two requesters, typically instruction fetch (port 0) and load/store (port 1).
- Each port uses a valid/ready request channel with byte addressing and access size. A response comes back exactly one cycle after acceptance.
- The block translates byte address and size into word address plus `bram32` write-subaddress code, lane-extracts sub-word read data and rejects misaligned accesses.
- It accepts at most one request per cycle, is fully pipelined (one access per cycle sustained) and contains no wait states.

## Interface

Parameters:

- `DEPTH`, 512, words in attached `bram32`; ADDR_WIDTH = $clog2(DEPTH), byte address width BA = ADDR_WIDTH+2

Ports (N = 0, 1):

- `i_clk`  in  1  clock
- `i_rst`  in  1  reset, synchronous, active-high
- `i_pN_req_valid`  in  1  request present
- `o_pN_req_ready`  out  1  request accepted this cycle (grant)
- `i_pN_req_addr`  in  BA  byte address
- `i_pN_req_we`  in  1  1 = store, 0 = load
- `i_pN_req_size`  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as misaligned)
- `i_pN_req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- `o_pN_resp_valid`  out  1  response for the request accepted previous cycle
- `o_pN_resp_rdata`  out  32  load data, zero-extended, right-aligned; 0 for stores, errors and when not valid
- `o_pN_resp_err`  out  1  misaligned/reserved access; qualified by resp_valid
- `o_mem_addr`  out  ADDR_WIDTH  to `bram32` i_addr
- `o_mem_data`  out  32  to `bram32` i_data
- `o_mem_we`  out  1  to `bram32` i_we
- `o_mem_subaddr`  out  3  to `bram32` i_wr_subaddr
- `i_mem_data`  in  32  from `bram32` o_data (valid one cycle after address)

## Operation

- **Grant**
  - Combinational from the valid inputs and arbitration state.
  - `o_pN_req_ready` = grant to port N; at most one port granted per cycle.
  - No grant while `i_rst` is high.
  - A port with only valid asserted is granted immediately.
- **Alignment**
  - Word requires addr[1:0]=0; half requires addr[0]=0; size 3 is always misaligned.
- **Memory drive (granted, aligned)**
  - `o_mem_addr` = addr[BA-1:2].
  - `o_mem_we` = req_we.
  - `o_mem_data` = wdata.
  - `o_mem_subaddr`: word 1; half 2+addr[1]; byte 4+addr[1:0].
- **Memory drive (no grant, or granted misaligned)**
  - `o_mem_we`=0, `o_mem_addr`=0, `o_mem_data`=0, `o_mem_subaddr`=0.
  - A misaligned store never modifies memory.
- **Response pipeline register**, capturing on grant:
  - port id, we, size, addr[1:0], err flag
- **Response (cycle after grant)**
  - Only the captured port sees resp_valid=1.
  - Load: word → i_mem_data; half → i_mem_data[16*addr[1] +: 16] zero-extended; byte → i_mem_data[8*addr[1:0] +: 8] zero-extended.
  - Store: rdata=0.
  - Error: err=1, rdata=0.
- **Response backpressure:** none. Requesters must consume the response in the cycle it is valid.
- **Arbitration with both valid:** fixed priority, port 0 wins (see Configuration for round-robin).
- **Ordering:** a store granted in cycle T is visible to a load from either port granted in T+1 or later; there is no same-cycle conflict because only one port is granted per cycle.

## Timing

- Request-to-response latency is exactly 1 cycle. Throughput is 1 request/cycle across both ports.
- Grant and memory drive are combinational from requests. Response outputs are registered state plus a combinational lane mux of `i_mem_data`.
- **Reset values:**
  - resp_valid=0, resp_err=0, rdata=0 on both ports
  - ready=0 while in reset
  - mem outputs 0
  - round-robin pointer "last granted = 1"
- **Reset mid-operation:** a request granted in the cycle before `i_rst` rises has its response suppressed (resp_valid=0 in the reset cycle). Its store has already been written.
- **First grant after reset:** may occur in the first cycle with `i_rst` low.

## Configuration

- **`BRAM32_ARB_RR_EN` defined:** round-robin on contention.
  - The port not granted last wins.
  - The pointer updates only on cycles with a grant.
  - Single-valid cycles update the pointer to that port.
- **`BRAM32_ARB_RR_EN` undefined:** fixed priority, port 0 always wins. Pointer logic is absent.

## Test plan

- **Word store/load.** Stimulus: p1 stores 0xDEADBEEF at byte addr 0x10, then p1 loads 0x10 next cycle. Required: mem subaddr=1, addr=4; load response rdata=0xDEADBEEF one cycle after grant.
- **Sub-word store and lane extraction.** Stimulus: byte store 0xAA at 0x13, half store 0x1234 at 0x10 (subaddr 7, then 2). Required:
  - word load = 0xAA001234
  - byte load 0x13 = 0x000000AA
  - half load 0x12 = 0x0000AA00
- **Misaligned.** Stimulus: word store at 0x02, half load at 0x05, size 3 at 0x00. Required: each gets resp_err=1 and rdata=0 next cycle, o_mem_we stays 0 and memory is unchanged.
- **Contention.** Stimulus: both ports valid for 4 cycles. Required:
  - without `BRAM32_ARB_RR_EN`: grants 0,0,0,0
  - with it, after reset: grants 0,1,0,1
  - responses return on the matching port each following cycle.
- **Back-to-back cross-port RAW.** Stimulus: p1 stores 0x55 to byte 0x20 in cycle T; p0 loads word 0x20 in T+1. Required: p0 rdata[7:0]=0x55 at T+2.
- **Reset mid-stream.** Stimulus: assert `i_rst` the cycle after a load grant. Required: no resp_valid during reset, all outputs at reset values, normal grant in the first cycle after deassertion.
